set_assoc_cache: RTL
====================

Name: set_assoc_cache

Overview:
Parametrised N-way set-associative cache for the memory subsystem, sitting between a requester and a slower memory port.
- Per-line valid bits and real tag compare.
- Valid/ready request handshake.
- Multi-word line refill FSM toward memory.
- Write-through, no-write-allocate policy.
- Round-robin replacement and single-cycle flush.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width; multiple of 8; byte-offset bits BO = log2(DATA_W/8)
NUM_SETS, 16, sets (power of 2); IDX = log2(NUM_SETS)
WAYS, 2, associativity (power of 2, >=1)
WORDS_PER_LINE, 4, words per line (power of 2); WO = log2(WORDS_PER_LINE); TAG = ADDR_W-IDX-WO-BO

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  invalidate all lines (honoured only in IDLE)
req_valid  in  1  request present
req_ready  out  1  cache can accept request
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address; low BO bits ignored
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  read data (0 for writes)
resp_hit  out  1  request hit in cache
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_write  out  1  memory write
mem_req_addr  out  ADDR_W  word-aligned memory address
mem_req_wdata  out  DATA_W  memory write data
mem_resp_valid  in  1  memory read data valid
mem_resp_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async): state IDLE; all valid bits 0; round-robin pointers 0; all outputs 0 except req_ready=1. Data/tag arrays are not cleared.
- Address split: offset = addr[BO+WO-1:BO], index = next IDX bits, tag = top TAG bits.
- req_ready=1 only in IDLE with flush=0. Request accepted on req_valid&&req_ready at a clock edge. Lookup is combinational on req_addr. Hit = valid && tag match in any way.
- Flush: flush=1 in IDLE clears all valid bits at that edge; req_ready=0 that cycle; no response. Flush outside IDLE is ignored.
- States: IDLE, RESP, WR_MEM, RF_REQ, RF_WAIT, RF_DONE.
- Read hit: IDLE->RESP. Next cycle resp_valid=1, resp_hit=1, resp_rdata=word; then IDLE. Latency 1, throughput 1 per 2 cycles.
- Write (hit or miss): on a hit, update the word in the hit way at acceptance. Go to WR_MEM: mem_req_valid=1, mem_req_write=1, addr/wdata = request. Hold stable until mem_req_ready. Then resp_valid=1, resp_hit=hit, resp_rdata=0, and return to IDLE. A write miss allocates nothing.
- Read miss:
  - Victim way = lowest-index invalid way in the set; else the set's round-robin pointer, which then increments mod WAYS.
  - Victim valid is cleared at acceptance.
  - RF_REQ: mem read at line_base + k*(DATA_W/8), k=0..WORDS_PER_LINE-1 ascending. Request held stable until mem_req_ready; then RF_WAIT.
  - RF_WAIT: on mem_resp_valid store word k. k<last -> RF_REQ; else RF_DONE.
  - One outstanding memory read at a time. mem_resp_valid outside RF_WAIT is ignored.
  - RF_DONE: write tag, set valid. Next cycle resp_valid=1, resp_hit=0, resp_rdata=requested word. Then IDLE.
- Reset mid-operation: aborts immediately; partially refilled victim stays invalid; no response issued.
- mem_req_* outputs are 0 whenever mem_req_valid=0.

Optional Feature:
SET_ASSOC_CACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Each increments on every accepted request classified hit/miss (reads and writes) and saturates at 0xFFFFFFFF. Both cleared by reset, not by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Defaults, memory returns data=address. Read 0x1234 -> mem reads 0x1230,0x1234,0x1238,0x123C; resp_rdata=0x1234, resp_hit=0. Re-read 0x1234 -> resp_valid 1 cycle after accept, hit=1, data 0x1234, no mem traffic.
2. After test 1, write 0x1238=0xDEADBEEF -> mem write 0x1238/0xDEADBEEF, resp_hit=1. Read 0x1238 -> hit, 0xDEADBEEF. Write 0x5000 (miss) -> mem write only. Read 0x5000 -> miss plus 4-word refill.
3. WAYS=2. Read 0x1234, 0x2234, 0x3234 (all set 3) -> third evicts way 0 (pointer). Read 0x2234 -> hit. Read 0x1234 -> miss.
4. Fill 0x1234, pulse flush 1 cycle in IDLE (req_ready=0 that cycle). Read 0x1234 -> miss and full refill.
5. Assert reset after 2 refill words -> all outputs 0 immediately, req_ready=1 after release. Read 0x1234 -> miss, 4-word refill.
6. Hold mem_req_ready=0 for 5 cycles during a refill and during a write -> mem_req_valid/addr/wdata stable throughout. Completion is correct afterwards. With STATS_EN, counters match hits/misses.

Source files
------------

// File: rtl/set_assoc_cache.sv
// N-way set-associative cache: write-through, no-write-allocate, multi-word line refill,
// round-robin replacement. Define SET_ASSOC_CACHE_STATS_EN to add hit_count/miss_count outputs.
module set_assoc_cache #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SETS       = 16,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef SET_ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int BO    = $clog2(DATA_W / 8);
  localparam int WO    = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int TAG   = ADDR_W - IDX - WO - BO;
  localparam int WO_W  = (WO > 0) ? WO : 1;
  localparam int IDX_W = (IDX > 0) ? IDX : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [WO_W-1:0]   LAST_WORD = WO_W'(WORDS_PER_LINE - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << BO;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << (BO + WO);

  typedef enum logic [2:0] {
    IDLE, RESP, WR_MEM, RF_REQ, RF_WAIT, RF_DONE
  } state_e;

  state_e state_q, state_d;

  logic [TAG-1:0]    tag_mem  [NUM_SETS][WAYS];
  logic [DATA_W-1:0] data_mem [NUM_SETS][WAYS][WORDS_PER_LINE];
  logic [WAYS-1:0]   valid_q  [NUM_SETS];
  logic [WAY_W-1:0]  rr_q     [NUM_SETS];

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TAG-1:0]    tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WO_W-1:0]   off_q;
  logic [WO_W-1:0]   cnt_q;
  logic [WAY_W-1:0]  way_q;
  logic              hit_q;

  logic [TAG-1:0]    req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WO_W-1:0]   req_off;
  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   way_free;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  free_way;
  logic [WAY_W-1:0]  victim;
  logic              hit;
  logic              any_free;
  logic [DATA_W-1:0] hit_word;
  logic              accept;
  logic              do_flush;
  logic              refill_beat;

  assign req_tag = req_addr[ADDR_W-1 -: TAG];
  assign req_idx = (IDX > 0) ? req_addr[BO + WO +: IDX_W] : '0;
  assign req_off = (WO > 0) ? req_addr[BO +: WO_W] : '0;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_hit[gi]  = valid_q[req_idx][gi] && (tag_mem[req_idx][gi] == req_tag);
    assign way_free[gi] = !valid_q[req_idx][gi];
  end

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w])  hit_way  = WAY_W'(w);
      if (way_free[w]) free_way = WAY_W'(w);
    end
  end

  assign hit         = |way_hit;
  assign any_free    = |way_free;
  assign victim      = any_free ? free_way : rr_q[req_idx];
  assign hit_word    = data_mem[req_idx][hit_way][req_off];
  assign accept      = req_valid && req_ready;
  assign do_flush    = (state_q == IDLE) && flush;
  assign refill_beat = (state_q == RF_WAIT) && mem_resp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_write) state_d = WR_MEM;
          else if (hit)  state_d = RESP;
          else           state_d = RF_REQ;
        end
      end
      RESP:    state_d = IDLE;
      WR_MEM:  if (mem_req_ready) state_d = RESP;
      RF_REQ:  if (mem_req_ready) state_d = RF_WAIT;
      RF_WAIT: if (mem_resp_valid) state_d = (cnt_q == LAST_WORD) ? RF_DONE : RF_REQ;
      RF_DONE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && !flush;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_hit   = hit_q;
      end
      WR_MEM: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = addr_q & WORD_MASK;
        mem_req_wdata = wdata_q;
      end
      RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = (addr_q & LINE_MASK) | (ADDR_W'(cnt_q) << BO);
      end
      default: ;
    endcase
  end

  // Request capture and refill word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        tag_q   <= req_tag;
        idx_q   <= req_idx;
        off_q   <= req_off;
        cnt_q   <= '0;
        hit_q   <= hit;
        way_q   <= hit ? hit_way : victim;
        rdata_q <= (!req_write && hit) ? hit_word : '0;
      end
      if (refill_beat) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == off_q) rdata_q <= mem_resp_rdata;
      end
    end
  end

  // The victim is invalidated up front so an aborted refill never leaves a stale line visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (do_flush) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else begin
      if (accept && !req_write && !hit) begin
        valid_q[req_idx][victim] <= 1'b0;
        if (!any_free) rr_q[req_idx] <= (rr_q[req_idx] == LAST_WAY) ? '0 : rr_q[req_idx] + 1'b1;
      end
      if (state_q == RF_DONE) valid_q[idx_q][way_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_write && hit) data_mem[req_idx][hit_way][req_off] <= req_wdata;
    if (refill_beat)                data_mem[idx_q][way_q][cnt_q] <= mem_resp_rdata;
    if (state_q == RF_DONE)         tag_mem[idx_q][way_q] <= tag_q;
  end

`ifdef SET_ASSOC_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
